placar_acumulador: RTL
======================

Name: placar_acumulador

Overview:
- Sequential score keeper for the basketball scoreboard. It sits directly upstream of the combinational 7-bit + 2-bit point adder, somador7bts.
- Turns point-button presses (1/2/3 points) and a team select into a registered 2-bit point value and a 7-bit score operand for the adder.
- Captures the adder sum back into per-team score registers, which feed the display stage.

Parameters:
- MAX_SCORE, 99, saturation ceiling for each team score (fits the two-digit display); legal range 3..127.
- SYNC_STAGES, 2, flop stages in the button synchronizer; legal range 2..4.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- btn_p1  input  1  raw "+1 point" button, active high, asynchronous to clk.
- btn_p2  input  1  raw "+2 points" button, active high, asynchronous.
- btn_p3  input  1  raw "+3 points" button, active high, asynchronous.
- team_sel  input  1  0 = home, 1 = away; sampled with the press.
- clr_placar  input  1  synchronous clear of both scores, active high.
- add_a  output  7  score operand to adder input A.
- add_b  output  2  point operand to adder input B (01 = 1, 10 = 2, 11 = 3).
- add_s  input  7  adder sum S.
- add_cout  input  1  adder carry out.
- score_home  output  7  home team score.
- score_away  output  7  away team score.
- busy  output  1  high while state is not IDLE.
- sat  output  1  one-cycle pulse when an update was clipped to MAX_SCORE.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. The clock port is clk and the reset port is rst.
- Reset values: all outputs 0, FSM in IDLE, synchronizer flops 0.
- Synchronizer: each btn passes through SYNC_STAGES flops. p1/p2/p3 are the synchronized levels.
- States: IDLE, ADD, HOLD.
- IDLE:
  - If any of p1/p2/p3 is high, register pts and tsel, then go to ADD.
  - pts selects the largest pressed value: p3 gives 11, else p2 gives 10, else p1 gives 01.
  - tsel is team_sel.
- ADD:
  - add_a shows the score of the selected team; add_b = pts.
  - At the clock edge ending ADD, the selected score loads the result and the FSM goes to HOLD.
  - Result rule: if add_cout is 1 or add_s > MAX_SCORE, load MAX_SCORE and pulse sat for the next cycle. Otherwise load add_s.
- HOLD: stay until p1, p2 and p3 are all low, then go to IDLE. One press always gives exactly one increment.
- Outside ADD, add_a and add_b are 0.
- Latency: if the synchronized press is first high in cycle k (IDLE), the score changes at the edge ending cycle k+1 and is visible in cycle k+2.
- clr_placar:
  - Highest synchronous priority. Both scores go to 0 and the FSM goes to HOLD, so a button held during clear does not count.
  - A clear during ADD aborts that update.
- Scores already at MAX_SCORE stay there; sat pulses on every press while at the ceiling.
- Asserting rst mid-operation forces the reset values immediately; no partial update survives.
- Arithmetic is done only by the external adder. This block only compares and clips.

Optional Feature:
- Macro: PLACAR_UNDO_EN.
- When defined:
  - Add input btn_undo, synchronized like the other buttons.
  - Add a last-update register holding team, previous score and a valid bit.
  - In IDLE, a synchronized btn_undo (when no point button is pressed) restores the previous score of that team. It then clears valid and goes to HOLD.
  - Undo with valid = 0 does nothing except go to HOLD.
  - clr_placar and rst clear valid.
- When not defined: no btn_undo port, no undo logic.

Decomposition:
- Shared package placar_pkg holds:
  - the state typedef (IDLE/ADD/HOLD);
  - point encodings PTS_1 = 2'b01, PTS_2 = 2'b10, PTS_3 = 2'b11;
  - SCORE_W = 7;
  - the default MAX_SCORE.
- One sub-module: sincroniza_botao, a parameterised SYNC_STAGES-deep synchronizer, instantiated once per button.
- The adder stays external. The bench instantiates somador7bts between add_a/add_b and add_s/add_cout.

Test Plan:
- Reset, then a btn_p2 pulse with team_sel = 0 → score_home = 2 in cycle k+2, score_away = 0, busy high for 2 cycles after detection.
- btn_p3 held 50 cycles with team_sel = 1 → score_away = 3 only; no repeat until release and a new press.
- btn_p1 and btn_p3 pressed together → +3 applied, not +4 or +1.
- score_home = 97, btn_p3 → score_home = 99 and sat pulses once. A further btn_p1 → stays 99 and sat pulses again.
- clr_placar asserted during ADD with btn_p2 held → both scores 0, no increment after clear, return to IDLE only after release.
- rst asserted during ADD, then with PLACAR_UNDO_EN: reset gives scores 0. Then +2, +3, undo → score 2; a second undo → no change.

Source files
------------

// File: rtl/placar_pkg.sv
// Shared types and constants for the scoreboard score keeper.
package placar_pkg;

  localparam int SCORE_W       = 7;
  localparam int MAX_SCORE_DEF = 99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] PTS_1 = 2'b01;
  localparam logic [1:0] PTS_2 = 2'b10;
  localparam logic [1:0] PTS_3 = 2'b11;

  // Largest pressed value wins when several point buttons are down together.
  function automatic logic [1:0] pts_sel(input logic p1, input logic p2, input logic p3);
    if (p3)      return PTS_3;
    else if (p2) return PTS_2;
    else if (p1) return PTS_1;
    else         return 2'b00;
  endfunction

endpackage

// File: rtl/sincroniza_botao.sv
// STAGES-deep flop chain bringing one asynchronous button level into clk.
module sincroniza_botao #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sr;

  // Shift the raw level through the chain; the last flop is the clean level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], din};
  end

  assign dout = sr[STAGES-1];

endmodule

// File: rtl/somador7bts.sv
// Combinational 7-bit + 2-bit point adder feeding the score keeper.
module somador7bts (
  input  logic [6:0] a,
  input  logic [1:0] b,
  output logic [6:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {6'b0, b};

endmodule

// File: rtl/placar_acumulador.sv
// Score keeper: turns point presses into adder operands and captures the
// clipped sum into per-team score registers.
// Optional undo of the last update is built when PLACAR_UNDO_EN is defined.
module placar_acumulador
  import placar_pkg::*;
#(
  parameter int MAX_SCORE   = MAX_SCORE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_p1,
  input  logic               btn_p2,
  input  logic               btn_p3,
`ifdef PLACAR_UNDO_EN
  input  logic               btn_undo,
`endif
  input  logic               team_sel,
  input  logic               clr_placar,
  output logic [SCORE_W-1:0] add_a,
  output logic [1:0]         add_b,
  input  logic [SCORE_W-1:0] add_s,
  input  logic               add_cout,
  output logic [SCORE_W-1:0] score_home,
  output logic [SCORE_W-1:0] score_away,
  output logic               busy,
  output logic               sat
);

`ifdef PLACAR_UNDO_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(MAX_SCORE);

  logic [NB-1:0] btn_raw, btn_s;
  logic          p1, p2, p3, any_pt, hold_any;

  state_t             state_q, state_d;
  logic [1:0]         pts_q;
  logic               tsel_q;
  logic [SCORE_W-1:0] sel_score, res;
  logic               clip;

`ifdef PLACAR_UNDO_EN
  logic               p_undo;
  logic               undo_vld, undo_team;
  logic [SCORE_W-1:0] undo_prev;
  assign btn_raw  = {btn_undo, btn_p3, btn_p2, btn_p1};
  assign p_undo   = btn_s[3];
  assign hold_any = any_pt | p_undo;
`else
  assign btn_raw  = {btn_p3, btn_p2, btn_p1};
  assign hold_any = any_pt;
`endif

  sincroniza_botao #(.STAGES(SYNC_STAGES)) u_sync [NB-1:0] (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_raw),
    .dout (btn_s)
  );

  assign p1     = btn_s[0];
  assign p2     = btn_s[1];
  assign p3     = btn_s[2];
  assign any_pt = p1 | p2 | p3;

  assign sel_score = tsel_q ? score_away : score_home;
  assign clip      = add_cout | (add_s > MAX_V);
  assign res       = clip ? MAX_V : add_s;

  assign add_a = (state_q == ADD) ? sel_score : '0;
  assign add_b = (state_q == ADD) ? pts_q     : 2'b00;
  assign busy  = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; clear overrides everything and parks in HOLD until release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_pt) state_d = ADD;
`ifdef PLACAR_UNDO_EN
        else if (p_undo) state_d = HOLD;
`endif
      end
      ADD:     state_d = HOLD;
      HOLD:    if (!hold_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr_placar) state_d = HOLD;
  end

  // Press capture, score update with clipping, saturation pulse and undo record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pts_q      <= 2'b00;
      tsel_q     <= 1'b0;
      score_home <= '0;
      score_away <= '0;
      sat        <= 1'b0;
`ifdef PLACAR_UNDO_EN
      undo_vld   <= 1'b0;
      undo_team  <= 1'b0;
      undo_prev  <= '0;
`endif
    end else begin
      sat <= 1'b0;
      if (clr_placar) begin
        score_home <= '0;
        score_away <= '0;
`ifdef PLACAR_UNDO_EN
        undo_vld   <= 1'b0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (any_pt) begin
              pts_q  <= pts_sel(p1, p2, p3);
              tsel_q <= team_sel;
            end
`ifdef PLACAR_UNDO_EN
            else if (p_undo && undo_vld) begin
              if (undo_team) score_away <= undo_prev;
              else           score_home <= undo_prev;
              undo_vld <= 1'b0;
            end
`endif
          end
          ADD: begin
            if (tsel_q) score_away <= res;
            else        score_home <= res;
            sat <= clip;
`ifdef PLACAR_UNDO_EN
            undo_vld  <= 1'b1;
            undo_team <= tsel_q;
            undo_prev <= sel_score;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
